// File: rtl/i2c_master_defines.sv
// Shared encodings for the I2C master byte controller: bit-level commands,
// byte FSM states and the mapping from FSM state to bit command.
package i2c_master_defines;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_START = 3'd1,
    CMD_STOP  = 3'd2,
    CMD_WRITE = 3'd3,
    CMD_READ  = 3'd4
  } bit_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } state_e;

  // Bit counter value loaded with each new byte (eight bits, MSB first)
  localparam logic [2:0] BIT_CNT_INIT = 3'd7;

  // Bit command issued while the byte FSM sits in a given state. The ACK
  // slot reverses direction: after a write we read the slave's ACK, after a
  // read we drive our own ACK/NACK.
  function automatic bit_cmd_e state_bit_cmd(input state_e st, input logic ack_after_read);
    bit_cmd_e cmd;
    case (st)
      ST_IDLE:  cmd = CMD_NOP;
      ST_START: cmd = CMD_START;
      ST_WRITE: cmd = CMD_WRITE;
      ST_READ:  cmd = CMD_READ;
      ST_ACK:   cmd = ack_after_read ? CMD_WRITE : CMD_READ;
      ST_STOP:  cmd = CMD_STOP;
      default:  cmd = CMD_NOP;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/i2c_master_shreg.sv
// Byte shift register with a down-counting bit counter. Bits leave at the MSB
// and enter at the LSB, so one register serves both transmit and receive.
module i2c_master_shreg
  import i2c_master_defines::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_shift,
  input  logic       i_sin,
  output logic       o_msb,
  output logic       o_cnt_zero,
  output logic [7:0] o_data
);

  logic [7:0] r_data;
  logic [2:0] r_cnt;

  // Load a fresh byte or shift one bit in at the LSB while counting down
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_data <= 8'h00;
      r_cnt  <= 3'd0;
    end else if (i_load) begin
      r_data <= i_data;
      r_cnt  <= BIT_CNT_INIT;
    end else if (i_shift) begin
      r_data <= {r_data[6:0], i_sin};
      r_cnt  <= (r_cnt == 3'd0) ? 3'd0 : (r_cnt - 3'd1);
    end else begin
      r_data <= r_data;
      r_cnt  <= r_cnt;
    end
  end

  assign o_msb      = r_data[7];
  assign o_cnt_zero = (r_cnt == 3'd0);
  assign o_data     = r_data;

endmodule

// File: rtl/i2c_master_byte_ctrl.sv
// I2C master byte controller: turns byte-level commands from the register
// block into a sequence of bit-level commands for the bit controller.
// Bit_cmd drops to NOP for one cycle after every Bit_ack, so each bit is a
// fresh command and a stale command is never re-executed.
module i2c_master_byte_ctrl
  import i2c_master_defines::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       I2C_en,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Read,
  input  logic       Write,
  input  logic       Tx_ack,
  input  logic [7:0] Tx_data,
  output logic [7:0] Rx_data,
  output logic       Rx_ack,
  output logic       I2C_done,
  output logic       I2C_al,
  output logic       I2C_busy,
  output logic [2:0] Bit_cmd,
  output logic       Bit_din,
  input  logic       Bit_ack,
  input  logic       Bit_dout,
  input  logic       Bit_al,
  input  logic       Bit_busy
);

  state_e     r_state;
  state_e     w_next_state;
  bit_cmd_e   r_bit_cmd;
  logic       r_bit_din;
  logic       r_rx_ack;
  logic       r_done;
  logic       r_al;
  logic       r_busy;
  logic       r_was_read;
  logic       w_load;
  logic       w_shift;
  logic       w_done;
  logic       w_al;
  logic       w_ack_cap;
  logic       w_msb;
  logic       w_cnt_zero;
  logic       w_any_cmd;
  logic [7:0] w_sr_data;

  assign w_any_cmd = Start | Stop | Read | Write;

  i2c_master_shreg u_shreg (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_load     (w_load),
    .i_data     (Tx_data),
    .i_shift    (w_shift),
    .i_sin      (Bit_dout),
    .o_msb      (w_msb),
    .o_cnt_zero (w_cnt_zero),
    .o_data     (w_sr_data)
  );

  // Byte FSM state register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: disable beats arbitration loss, which beats Bit_ack
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_done       = 1'b0;
    w_al         = 1'b0;
    w_ack_cap    = 1'b0;
    if (!I2C_en) begin
      w_next_state = ST_IDLE;
    end else if (Bit_al && (r_state != ST_IDLE)) begin
      w_next_state = ST_IDLE;
      w_al         = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // r_done blocks re-acceptance while the register block clears its command
          if (!r_done && w_any_cmd) begin
            w_load = 1'b1;
            if (Start) begin
              w_next_state = ST_START;
            end else if (Read) begin
              w_next_state = ST_READ;
            end else if (Write) begin
              w_next_state = ST_WRITE;
            end else begin
              w_next_state = ST_STOP;
            end
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_START: begin
          if (Bit_ack) begin
            w_next_state = Read ? ST_READ : ST_WRITE;
          end else begin
            w_next_state = ST_START;
          end
        end
        ST_WRITE, ST_READ: begin
          if (Bit_ack) begin
            w_shift      = 1'b1;
            w_next_state = w_cnt_zero ? ST_ACK : r_state;
          end else begin
            w_next_state = r_state;
          end
        end
        ST_ACK: begin
          if (Bit_ack) begin
            w_ack_cap = !r_was_read;
            if (Stop) begin
              w_next_state = ST_STOP;
            end else begin
              w_next_state = ST_IDLE;
              w_done       = 1'b1;
            end
          end else begin
            w_next_state = ST_ACK;
          end
        end
        ST_STOP: begin
          if (Bit_ack) begin
            w_next_state = ST_IDLE;
            w_done       = 1'b1;
          end else begin
            w_next_state = ST_STOP;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Registered bit command/data, status pulses and captured slave ACK
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_bit_cmd  <= CMD_NOP;
      r_bit_din  <= 1'b0;
      r_rx_ack   <= 1'b0;
      r_done     <= 1'b0;
      r_al       <= 1'b0;
      r_busy     <= 1'b0;
      r_was_read <= 1'b0;
    end else begin
      r_done <= w_done;
      r_al   <= w_al;
      r_busy <= Bit_busy;
      if (w_ack_cap) begin
        r_rx_ack <= Bit_dout;
      end
      if (r_state == ST_READ) begin
        r_was_read <= 1'b1;
      end else if (r_state == ST_WRITE) begin
        r_was_read <= 1'b0;
      end
      if (Bit_ack || Bit_al || !I2C_en) begin
        r_bit_cmd <= CMD_NOP;
      end else begin
        r_bit_cmd <= state_bit_cmd(r_state, r_was_read);
      end
      r_bit_din <= (r_state == ST_ACK) ? Tx_ack : w_msb;
    end
  end

  assign Rx_data  = w_sr_data;
  assign Rx_ack   = r_rx_ack;
  assign I2C_done = r_done;
  assign I2C_al   = r_al;
  assign I2C_busy = r_busy;
  assign Bit_cmd  = r_bit_cmd;
  assign Bit_din  = r_bit_din;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Self-checking bench for i2c_master_byte_ctrl. A bit-controller model acks
// each non-NOP Bit_cmd four cycles after it appears; every command it sees is
// popped from a scoreboard queue filled when the byte command is issued.
module tb_i2c_master_byte_ctrl;
  import i2c_master_defines::*;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       I2C_en = 1'b0;
  logic       Start = 1'b0, Stop = 1'b0, Read = 1'b0, Write = 1'b0;
  logic       Tx_ack = 1'b0;
  logic [7:0] Tx_data = 8'h00;
  logic [7:0] Rx_data;
  logic       Rx_ack, I2C_done, I2C_al, I2C_busy, Bit_din;
  logic [2:0] Bit_cmd;
  logic       Bit_ack = 1'b0, Bit_dout = 1'b0, Bit_al = 1'b0, Bit_busy = 1'b0;

  i2c_master_byte_ctrl dut (
    .Clk(Clk), .Rst(Rst), .I2C_en(I2C_en), .Start(Start), .Stop(Stop),
    .Read(Read), .Write(Write), .Tx_ack(Tx_ack), .Tx_data(Tx_data),
    .Rx_data(Rx_data), .Rx_ack(Rx_ack), .I2C_done(I2C_done), .I2C_al(I2C_al),
    .I2C_busy(I2C_busy), .Bit_cmd(Bit_cmd), .Bit_din(Bit_din), .Bit_ack(Bit_ack),
    .Bit_dout(Bit_dout), .Bit_al(Bit_al), .Bit_busy(Bit_busy)
  );

  initial forever #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0] cmd;
    logic       din;
    logic       chk_din;
  } exp_t;

  exp_t exp_q[$];
  logic dout_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;
  int   n_al    = 0;
  int   n_starts = 0;

  // bit-controller model state
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  logic [2:0] m_cmd = 3'd0;
  int         m_wr_idx = 0;
  int         al_mode = 0;   // 1: al mid WRITE bit al_wr, 2: al together with next ack
  int         al_wr = 0;
  logic       ack_bit = 1'b0;
  exp_t       m_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic d, input logic cd);
    exp_t e;
    e.cmd = c; e.din = d; e.chk_din = cd;
    exp_q.push_back(e);
  endtask

  task automatic push_write_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) push(CMD_WRITE, b[i], 1'b1);
  endtask

  task automatic clear_cmds();
    Start = 1'b0; Stop = 1'b0; Read = 1'b0; Write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  // wait (bounded) for the end of a command: done or arbitration lost
  task automatic wait_end(input string tag, input int budget);
    int k;
    k = 0;
    while (!(I2C_done === 1'b1 || I2C_al === 1'b1) && k < budget) begin
      @(negedge Clk);
      k++;
    end
    check(tag, {31'd0, k < budget}, 32'd1);
  endtask

  // Bit-controller model, driven on the falling edge
  always @(negedge Clk) begin
    Bit_ack = 1'b0;
    Bit_al  = 1'b0;
    if (Rst) begin
      m_busy   = 1'b0;
      m_cnt    = 0;
      Bit_dout = 1'b0;
    end else if (m_busy) begin
      m_cnt++;
      if (al_mode == 1 && m_cmd == CMD_WRITE && m_wr_idx == al_wr && m_cnt == 2) begin
        Bit_al  = 1'b1;
        m_busy  = 1'b0;
        al_mode = 0;
      end else if (m_cnt == 4) begin
        Bit_ack = 1'b1;
        m_busy  = 1'b0;
        if (m_cmd == CMD_READ) Bit_dout = (dout_q.size() > 0) ? dout_q.pop_front() : ack_bit;
        else Bit_dout = 1'b0;
        if (al_mode == 2) begin
          Bit_al  = 1'b1;
          al_mode = 0;
        end
      end
    end else if (Bit_cmd != CMD_NOP) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      m_cmd  = Bit_cmd;
      n_starts++;
      if (Bit_cmd == CMD_WRITE) m_wr_idx++;
      if (exp_q.size() == 0) begin
        check("sb_extra_cmd", {29'd0, Bit_cmd}, {29'd0, CMD_NOP});
      end else begin
        m_e = exp_q.pop_front();
        check("sb_cmd", {29'd0, Bit_cmd}, {29'd0, m_e.cmd});
        if (m_e.chk_din) check("sb_din", {31'd0, Bit_din}, {31'd0, m_e.din});
      end
    end
  end

  // Pulse counters for done and arbitration lost
  always @(negedge Clk) begin
    if (I2C_done === 1'b1) n_done++;
    if (I2C_al === 1'b1) n_al++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int bad;
    int s0;
    // reset values
    idle(3);
    check("rst_bit_cmd", {29'd0, Bit_cmd}, {29'd0, CMD_NOP});
    check("rst_rx_data", {24'd0, Rx_data}, 32'h00);
    check("rst_outs", {27'd0, Rx_ack, I2C_done, I2C_al, I2C_busy, Bit_din}, 32'd0);
    Rst = 1'b0;
    idle(2);

    // I2C_busy is Bit_busy delayed by one register
    Bit_busy = 1'b1;
    #1 check("busy_lag", {31'd0, I2C_busy}, 32'd0);
    @(negedge Clk);
    check("busy_set", {31'd0, I2C_busy}, 32'd1);
    Bit_busy = 1'b0;
    @(negedge Clk);
    check("busy_clr", {31'd0, I2C_busy}, 32'd0);

    // disabled core ignores a held Write
    I2C_en = 1'b0; Write = 1'b1; Tx_data = 8'h55;
    bad = 0; s0 = n_starts; n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Bit_cmd !== CMD_NOP) bad++;
    end
    check("dis_nop", bad, 0);
    check("dis_starts", n_starts - s0, 0);
    clear_cmds();
    I2C_en = 1'b1;
    idle(2);

    // Start+Write 0xA5, slave ACK=0; commands held through the done cycle
    ack_bit = 1'b0; n_done = 0; n_al = 0;
    push(CMD_START, 1'b0, 1'b0); push_write_byte(8'hA5); push(CMD_READ, 1'b0, 1'b0);
    Tx_data = 8'hA5; Start = 1'b1; Write = 1'b1;
    wait_end("wr_timeout", 300);
    @(negedge Clk);
    clear_cmds();
    idle(12);
    check("wr_done_cnt", n_done, 1);
    check("wr_al_cnt", n_al, 0);
    check("wr_sb_empty", exp_q.size(), 0);
    check("wr_rx_ack", {31'd0, Rx_ack}, 32'd0);

    // Start+Write+Stop 0x3C, slave NACK=1
    ack_bit = 1'b1; n_done = 0;
    push(CMD_START, 1'b0, 1'b0); push_write_byte(8'h3C);
    push(CMD_READ, 1'b0, 1'b0); push(CMD_STOP, 1'b0, 1'b0);
    Tx_data = 8'h3C; Start = 1'b1; Write = 1'b1; Stop = 1'b1;
    wait_end("wrs_timeout", 300);
    clear_cmds();
    idle(12);
    check("wrs_done_cnt", n_done, 1);
    check("wrs_sb_empty", exp_q.size(), 0);
    check("wrs_rx_ack", {31'd0, Rx_ack}, 32'd1);

    // Read+Stop with Tx_ack=1, slave sends 0x3C
    ack_bit = 1'b0; n_done = 0; n_al = 0;
    for (int i = 0; i < 8; i++) push(CMD_READ, 1'b0, 1'b0);
    push(CMD_WRITE, 1'b1, 1'b1); push(CMD_STOP, 1'b0, 1'b0);
    dout_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    Tx_data = 8'h00; Tx_ack = 1'b1; Read = 1'b1; Stop = 1'b1;
    wait_end("rd_timeout", 300);
    clear_cmds();
    idle(12);
    check("rd_done_cnt", n_done, 1);
    check("rd_al_cnt", n_al, 0);
    check("rd_sb_empty", exp_q.size(), 0);
    check("rd_rx_data", {24'd0, Rx_data}, 32'h3C);

    // Stop-only command
    n_done = 0;
    push(CMD_STOP, 1'b0, 1'b0);
    Stop = 1'b1;
    wait_end("stop_timeout", 100);
    clear_cmds();
    idle(12);
    check("stop_done_cnt", n_done, 1);
    check("stop_sb_empty", exp_q.size(), 0);

    // arbitration lost during the 3rd WRITE bit
    n_done = 0; n_al = 0; m_wr_idx = 0; al_mode = 1; al_wr = 3;
    push(CMD_START, 1'b0, 1'b0);
    push(CMD_WRITE, 1'b1, 1'b1); push(CMD_WRITE, 1'b0, 1'b1); push(CMD_WRITE, 1'b1, 1'b1);
    Tx_data = 8'hA5; Start = 1'b1; Write = 1'b1;
    wait_end("al_timeout", 300);
    check("al_pulse", {31'd0, I2C_al}, 32'd1);
    check("al_cmd_nop", {29'd0, Bit_cmd}, {29'd0, CMD_NOP});
    clear_cmds();
    idle(12);
    check("al_cnt", n_al, 1);
    check("al_no_done", n_done, 0);
    check("al_sb_empty", exp_q.size(), 0);

    // Bit_al and Bit_ack in the same cycle (on the START ack)
    n_done = 0; n_al = 0; al_mode = 2;
    push(CMD_START, 1'b0, 1'b0);
    Tx_data = 8'h5A; Start = 1'b1; Write = 1'b1;
    wait_end("alack_timeout", 100);
    check("alack_pulse", {31'd0, I2C_al}, 32'd1);
    check("alack_cmd_nop", {29'd0, Bit_cmd}, {29'd0, CMD_NOP});
    clear_cmds();
    idle(12);
    check("alack_cnt", n_al, 1);
    check("alack_no_done", n_done, 0);
    check("alack_sb_empty", exp_q.size(), 0);

    // reset asserted during the 5th READ bit
    n_done = 0; n_al = 0; al_mode = 0;
    for (int i = 0; i < 5; i++) push(CMD_READ, 1'b0, 1'b0);
    dout_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    Bit_busy = 1'b1; Tx_data = 8'hFF; Tx_ack = 1'b0; Read = 1'b1; Stop = 1'b1;
    bad = 0;
    while (exp_q.size() != 0 && bad < 400) begin
      @(negedge Clk);
      bad++;
    end
    check("rstmid_timeout", {31'd0, bad < 400}, 32'd1);
    check("rstmid_pre_din", {31'd0, Bit_din}, 32'd1);
    Rst = 1'b1;
    #1;
    check("rstmid_bit_cmd", {29'd0, Bit_cmd}, {29'd0, CMD_NOP});
    check("rstmid_rx_data", {24'd0, Rx_data}, 32'h00);
    check("rstmid_outs", {27'd0, Rx_ack, I2C_done, I2C_al, I2C_busy, Bit_din}, 32'd0);
    clear_cmds();
    Bit_busy = 1'b0;
    dout_q.delete();
    idle(3);
    Rst = 1'b0;
    idle(12);
    check("rstmid_no_pulse", n_done + n_al, 0);
    check("rstmid_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte_ctrl.md
I2C_MASTER_BYTE_CTRL -- requirements
Module: i2c_master_byte_ctrl

Interface
REQ-001 SHALL have one clock, Clk; reset Rst is asynchronous and active-high.
REQ-002 Ports (name direction width meaning), in this order:
- Clk  in  1  master clock
- Rst  in  1  async active-high reset
- I2C_en  in  1  core enable
- Start, Stop, Read, Write  in  1 each  commands, held by the register block until I2C_done
- Tx_ack  in  1  ACK bit sent as receiver (0=ACK, 1=NACK)
- Tx_data  in  8  byte to transmit
- Rx_data  out  8  received byte
- Rx_ack  out  1  ACK bit received from slave
- I2C_done  out  1  one-cycle pulse, command completed
- I2C_al  out  1  one-cycle pulse, arbitration lost
- I2C_busy  out  1  bus busy
- Bit_cmd  out  3  bit-level command: NOP, START, STOP, WRITE or READ
- Bit_din  out  1  bit to drive for WRITE
- Bit_ack  in  1  one-cycle pulse, bit command completed
- Bit_dout  in  1  bit sampled by the bit controller
- Bit_al  in  1  arbitration lost, from the bit controller
- Bit_busy  in  1  bus busy, from the bit controller

Function
REQ-003 SHALL implement an FSM with states IDLE, START, WRITE, READ, ACK and STOP.
REQ-004 In IDLE, commands SHALL be accepted only when I2C_en=1, I2C_done=0 and at least one command is set.
REQ-005 On acceptance, the FSM SHALL apply priority Start > Read > Write > Stop to choose the next state.
REQ-006 On acceptance, the FSM SHALL load Tx_data into the shift register and set the bit counter to 7.
REQ-007 Bit_cmd SHALL be registered and SHALL change one cycle after a state change.
REQ-008 Bit_cmd SHALL stay stable until Bit_ack.
REQ-009 Bit_cmd SHALL be NOP in IDLE.
REQ-010 START: on Bit_ack, the FSM SHALL go to READ if Read=1, otherwise to WRITE.
REQ-011 WRITE: Bit_din SHALL equal the shift register MSB, and the register SHALL shift left on each Bit_ack.
REQ-012 READ: Bit_dout SHALL be shifted into the register LSB on each Bit_ack.
REQ-013 In WRITE and READ, the counter SHALL decrement on each Bit_ack, and a Bit_ack with counter=0 SHALL move the FSM to ACK.
REQ-014 ACK after a write: Bit_cmd SHALL be READ, and Bit_dout SHALL be captured into Rx_ack on Bit_ack.
REQ-015 ACK after a read: Bit_cmd SHALL be WRITE with Bit_din=Tx_ack.
REQ-016 ACK exit: on Bit_ack the FSM SHALL go to STOP if Stop=1, otherwise to IDLE with I2C_done=1.
REQ-017 STOP: on Bit_ack the FSM SHALL go to IDLE with I2C_done=1.
REQ-018 A Stop-only command SHALL go directly IDLE -> STOP.
REQ-019 Rx_data SHALL equal the shift register contents; they are valid from the I2C_done cycle until the next accepted command.
REQ-020 I2C_done SHALL be high for exactly one cycle per completed command.
REQ-021 The FSM SHALL ignore commands in the I2C_done cycle, which guarantees no retrigger while the register block autoclears its command register.
REQ-022 Bit_al=1 in any non-IDLE state SHALL force IDLE, Bit_cmd=NOP next cycle and I2C_al=1 for one cycle, with I2C_done held at 0.
REQ-023 If Bit_al and Bit_ack are both high in the same cycle, Bit_al SHALL win.
REQ-024 I2C_en=0 SHALL force IDLE and Bit_cmd=NOP next cycle, with no I2C_done and no I2C_al.
REQ-025 I2C_busy SHALL be Bit_busy, registered.

Reset
REQ-026 While Rst=1, the FSM SHALL be in IDLE.
REQ-027 While Rst=1: Bit_cmd=NOP; shift register=0x00; counter=0.
REQ-028 While Rst=1: Rx_data, Rx_ack, I2C_done, I2C_al, I2C_busy and Bit_din SHALL all be 0.
REQ-029 Reset asserted mid-transfer SHALL abort immediately to these values, with no done or al pulse.

Structure
REQ-030 Bit command encodings and FSM state encodings SHALL live in the shared i2c_master_defines file.
REQ-031 The shift register and bit counter SHALL be one sub-module, i2c_master_shreg, with load, shift, serial-in, MSB-out and count-zero ports.

Verification (bench uses a bit-controller model that pulses Bit_ack 4 cycles after each non-NOP Bit_cmd)
REQ-032 Start+Write, Tx_data=0xA5, model returns Bit_dout=0 at the ack phase -> the bench SHALL observe:
- Bit_cmd sequence START, WRITE x8 with Bit_din 1,0,1,0,0,1,0,1, then READ;
- one I2C_done pulse;
- Rx_ack=0.
REQ-033 Read+Stop with Tx_ack=1, model returns bits 0,0,1,1,1,1,0,0 -> the bench SHALL observe:
- Bit_cmd sequence READ x8, WRITE with Bit_din=1, then STOP;
- one I2C_done pulse;
- Rx_data=0x3C.
REQ-034 Bit_al pulsed during the 3rd WRITE bit -> the bench SHALL observe one I2C_al pulse, no I2C_done and Bit_cmd=NOP on the next cycle.
REQ-035 Stop-only command -> the bench SHALL observe a single STOP followed by one I2C_done pulse; with I2C_en=0 and Write=1 held, Bit_cmd SHALL stay NOP.
REQ-036 Rst=1 asserted during the 5th READ bit -> all outputs SHALL reach reset values immediately.
REQ-037 Bit_al and Bit_ack high in the same cycle -> the al behaviour of REQ-022 SHALL be observed.
